// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end core package: fetch FSM state encodings, pair size and reset PC.
// Optional perf counters in fetch_sequencer are enabled with `define FETCH_PERF_CNT_EN.
package fetch_sequencer_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_WAIT  = 2'd2;
    localparam fetch_state_t ST_FLUSH = 2'd3;

    localparam logic [31:0] FETCH_BYTES      = 32'd8;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pair_addr(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_npc_sel.sv
// Next-PC selection: redirect beats predicted target, which beats sequential pc+8.
module fetch_npc_sel
    import fetch_sequencer_pkg::*;
(
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] npc_o
);

    always_comb begin
        if (redirect_i) begin
            npc_o = redirect_pc_i;
        end else if (pred_taken_i) begin
            npc_o = pred_target_i;
        end else begin
            npc_o = pc_i + FETCH_BYTES;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: pair requests, decode hand-off with hold, redirect flush.
// Optional saturating perf counters are built only with `define FETCH_PERF_CNT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          REDIRECT_Q = 1
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        frontend_we_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        pred_taken_i,
    input  logic        pred_slot_i,
    input  logic [31:0] pred_target_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic        zero_1_o,
    output logic        flush_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_flush_o,
    output logic [31:0] perf_stall_o
`endif
);

    generate
        if (REDIRECT_Q != 1) begin : g_redirect_q_check
            $error("fetch_sequencer: only REDIRECT_Q = 1 is supported");
        end
    endgenerate

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         held_q, held_d;
    logic         held_taken_q, held_taken_d;
    logic         held_slot_q, held_slot_d;
    logic [31:0]  held_target_q, held_target_d;

    logic        take_redirect, req_phase, holding, got_ack, deliver, advance;
    logic        cur_taken, cur_slot;
    logic [31:0] cur_target, npc;

    assign take_redirect = redirect_i && (state_q != ST_BOOT);
    assign holding       = (state_q == ST_WAIT) && held_q;
    assign req_phase     = (state_q == ST_FETCH) || ((state_q == ST_WAIT) && !held_q);
    assign got_ack       = req_phase && imem_ack_i && !take_redirect;
    assign deliver       = got_ack || (holding && !take_redirect);
    assign advance       = deliver && frontend_we_i;

    // A held pair keeps the prediction that arrived with it, not the live predictor.
    assign cur_taken  = holding ? held_taken_q  : pred_taken_i;
    assign cur_slot   = holding ? held_slot_q   : pred_slot_i;
    assign cur_target = holding ? held_target_q : pred_target_i;

    fetch_npc_sel u_npc_sel (
        .redirect_i    (take_redirect),
        .redirect_pc_i (redirect_pc_i),
        .pred_taken_i  (cur_taken),
        .pred_target_i (cur_target),
        .pc_i          (pc_q),
        .npc_o         (npc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        held_d        = held_q;
        held_taken_d  = held_taken_q;
        held_slot_d   = held_slot_q;
        held_target_d = held_target_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH, ST_WAIT: begin
                if (take_redirect) begin
                    pc_d    = npc;
                    state_d = ST_FLUSH;
                    held_d  = 1'b0;
                end else if (advance) begin
                    pc_d    = npc;
                    state_d = ST_FETCH;
                    held_d  = 1'b0;
                end else if (got_ack) begin
                    state_d       = ST_WAIT;
                    held_d        = 1'b1;
                    held_taken_d  = pred_taken_i;
                    held_slot_d   = pred_slot_i;
                    held_target_d = pred_target_i;
                end else if (state_q == ST_FETCH) begin
                    state_d = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (take_redirect) begin
                    pc_d = npc;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            held_q        <= 1'b0;
            held_taken_q  <= 1'b0;
            held_slot_q   <= 1'b0;
            held_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            held_q        <= held_d;
            held_taken_q  <= held_taken_d;
            held_slot_q   <= held_slot_d;
            held_target_q <= held_target_d;
        end
    end

    // No request goes out in a redirect cycle: its data would be discarded anyway.
    assign imem_req_o    = req_phase && !take_redirect;
    assign imem_addr_o   = pair_addr(pc_q);
    assign fetch_valid_o = deliver;
    assign fetch_pc_o    = deliver ? pc_q : 32'h0;
    assign zero_1_o      = deliver && ((cur_taken && !cur_slot) || pc_q[2]);
    assign flush_o       = take_redirect || (state_q == ST_FLUSH);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_flush_q, perf_stall_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (advance && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (take_redirect && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if ((state_q == ST_WAIT) && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_flush_o = perf_flush_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [2:0] SHALL be zero.
REQ-002 Parameter REDIRECT_Q, default 1, depth of the pending-redirect holding register (1 only in this revision).
REQ-003 clock_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 frontend_we_i  in  1  front-end pipeline advance enable.
REQ-006 imem_req_o  out  1  instruction-memory request.
REQ-007 imem_addr_o  out  32  8-byte-aligned fetch-pair address.
REQ-008 imem_ack_i  in  1  returned 64-bit pair valid this cycle.
REQ-009 pred_taken_i  in  1  predictor says taken for the current pair.
REQ-010 pred_slot_i  in  1  slot holding the predicted branch (0 = upper word).
REQ-011 pred_target_i  in  32  predicted target.
REQ-012 redirect_i  in  1  backend mispredict or not-a-branch correction.
REQ-013 redirect_pc_i  in  32  corrected PC.
REQ-014 fetch_valid_o  out  1  pair delivered to the decode stage this cycle.
REQ-015 fetch_pc_o  out  32  address of the delivered pair.
REQ-016 zero_1_o  out  1  squash slot 1 of the delivered pair.
REQ-017 flush_o  out  1  front-end flush.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, WAIT and FLUSH.
REQ-019 BOOT SHALL move to FETCH one cycle after reset release, with pc = RESET_PC.
REQ-020 In FETCH: imem_req_o=1 and imem_addr_o={pc[31:3],3'b000}; no ack -> WAIT (request held, address stable).
REQ-021 In WAIT: imem_req_o=1 with the same address until imem_ack_i.
REQ-022 On ack with frontend_we_i=1: fetch_valid_o=1 and fetch_pc_o=pc; next pc = pred_target_i if pred_taken_i, else pc+8 (mod 2^32, wrap from 32'hFFFF_FFF8 to 0).
REQ-023 zero_1_o=1 on a delivered pair when pred_taken_i=1 and pred_slot_i=0, or when pc[2]=1.
REQ-024 On ack with frontend_we_i=0: the pair SHALL be held and fetch_valid_o kept asserted, pc unchanged, no new request, until frontend_we_i=1.
REQ-025 redirect_i=1 in any non-BOOT state SHALL assert flush_o the same cycle, load pc=redirect_pc_i and enter FLUSH; fetch_valid_o=0.
REQ-026 FLUSH SHALL last exactly one cycle with flush_o=1 and imem_req_o=0, then go to FETCH.
REQ-027 A redirect in FLUSH SHALL reload pc and restart the one-cycle FLUSH.
REQ-028 An ack arriving in the cycle of a redirect, or during FLUSH, SHALL be discarded.
REQ-029 redirect_i SHALL take priority over pred_taken_i and over frontend_we_i=0.

Reset
REQ-030 While reset_n_i=0: state=BOOT, pc=RESET_PC, and imem_req_o, fetch_valid_o, zero_1_o, flush_o=0; fetch_pc_o=0 and imem_addr_o=RESET_PC.
REQ-031 Reset assertion mid-WAIT SHALL abandon the outstanding request; acks arriving in BOOT SHALL be ignored.

Configuration
REQ-032 With FETCH_PERF_CNT_EN defined: 32-bit outputs perf_fetch_o (delivered pairs), perf_flush_o (FLUSH entries) and perf_stall_o (WAIT or held cycles), saturating, cleared by reset.
REQ-033 Without FETCH_PERF_CNT_EN: those ports and counters SHALL be absent; behaviour otherwise identical.

Structure
REQ-034 The FSM state enum, FETCH_BYTES=8 and the default reset PC SHALL live in the shared core package.
REQ-035 Next-PC selection (redirect, predicted target, pc+8) SHALL be one sub-module, fetch_npc_sel; the FSM stays in fetch_sequencer.

Verification
REQ-036 Reset release with RESET_PC=0 and ack every cycle -> imem_addr_o sequence 0x0, 0x8, 0x10; fetch_valid_o=1 from the cycle of the first ack.
REQ-037 Ack delayed 3 cycles at 0x40 -> imem_addr_o held at 0x40 for 4 cycles; fetch_pc_o=0x40 exactly once.
REQ-038 pred_taken_i=1, pred_slot_i=0, target 0x200 at pc 0x10 -> zero_1_o=1 for that pair; next imem_addr_o=0x200.
REQ-039 redirect_i=1 to 0x1004 while in WAIT -> flush_o=1 for 2 cycles, the ack in the flush cycle is dropped, then imem_addr_o=0x1000 with zero_1_o=1 on delivery.
REQ-040 frontend_we_i=0 for 5 cycles after an ack -> fetch_valid_o and fetch_pc_o stable, no new request; pc advances by 8 on release.
REQ-041 pc=0xFFFF_FFF8 with no prediction -> next fetch address 0x0000_0000; with FETCH_PERF_CNT_EN, perf_fetch_o increments by 1 per delivered pair.
